// File: rtl/robot_step_controller.sv
// Step sequencer between debounced wall sensors, the wall-following robot FSM and the drive motors.
// One robot decision per step; forward/rotate decisions become fixed-length motor pulses.
module robot_step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MOVE_CYCLES     = 8,
    parameter int ROTATE_CYCLES   = 6,
    parameter int MAX_ROTATIONS   = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             head_raw,
    input  logic             left_raw,
    input  logic             robot_front,
    input  logic             robot_rotate,
    output logic             sens_head,
    output logic             sens_left,
    output logic             step_en,
    output logic             motor_fwd,
    output logic             motor_turn,
    output logic             busy,
    output logic             stuck,
    output logic             cmd_err,
    output logic [CNT_W-1:0] move_count
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMAX = (MOVE_CYCLES > ROTATE_CYCLES) ? MOVE_CYCLES : ROTATE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_ROTATIONS + 1);

    typedef enum logic [2:0] {IDLE, SAMPLE, DECIDE, MOVE, TURN, STUCK} state_t;

    state_t          state, state_nxt;
    logic [1:0]      raw, sens, sat;
    logic [TW-1:0]   timer;
    logic [RW-1:0]   rot_run;
    logic [CNT_W-1:0] count;
    logic            stable, illegal;

    assign raw = {left_raw, head_raw};

    for (genvar i = 0; i < 2; i++) begin : g_deb
        logic          s1, s2, cand, sv;
        logic [DW-1:0] cnt;
        // cnt is the run length of the synced value cand, saturating at DEBOUNCE_CYCLES
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                cand <= 1'b0;
                sv   <= 1'b0;
                cnt  <= '0;
            end else begin
                s1 <= raw[i];
                s2 <= s1;
                if (s2 != cand) begin
                    cand <= s2;
                    cnt  <= DW'(1);
                    if (DEBOUNCE_CYCLES == 1) sv <= s2;
                end else if (cnt != DW'(DEBOUNCE_CYCLES)) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == DW'(DEBOUNCE_CYCLES - 1)) sv <= cand;
                end
            end
        end
        assign sens[i] = sv;
        assign sat[i]  = (cnt == DW'(DEBOUNCE_CYCLES));
    end

    assign sens_head  = sens[0];
    assign sens_left  = sens[1];
    assign stable     = &sat;
    assign illegal    = (robot_front == robot_rotate);
    assign move_count = count;

    always_comb begin
        state_nxt  = state;
        step_en    = 1'b0;
        motor_fwd  = 1'b0;
        motor_turn = 1'b0;
        busy       = 1'b1;
        stuck      = 1'b0;
        cmd_err    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (enable) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (!enable)     state_nxt = IDLE;
                else if (stable) state_nxt = DECIDE;
            end
            DECIDE: begin
                step_en = 1'b1;
                cmd_err = illegal;
                if (illegal)          state_nxt = SAMPLE;
                else if (robot_front) state_nxt = MOVE;
                else                  state_nxt = TURN;
            end
            MOVE: begin
                motor_fwd = 1'b1;
                if (timer == '0) state_nxt = enable ? SAMPLE : IDLE;
            end
            TURN: begin
                motor_turn = 1'b1;
                if (timer == '0)
                    state_nxt = (rot_run == RW'(MAX_ROTATIONS)) ? STUCK : (enable ? SAMPLE : IDLE);
            end
            STUCK: begin
                busy  = 1'b0;
                stuck = 1'b1;
                if (!enable) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            rot_run <= '0;
            count   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                DECIDE: if (!illegal) begin
                    // timer counts the remaining motion cycles after the current one
                    timer   <= robot_front ? TW'(MOVE_CYCLES - 1) : TW'(ROTATE_CYCLES - 1);
                    rot_run <= robot_front ? '0 : rot_run + 1'b1;
                end
                MOVE: begin
                    if (timer != '0)       timer <= timer - 1'b1;
                    else if (count != '1)  count <= count + 1'b1;
                end
                TURN:  if (timer != '0) timer <= timer - 1'b1;
                STUCK: if (!enable) rot_run <= '0;
                default: ;
            endcase
        end
    end
endmodule
